// File: rtl/schedule_editor.sv
// schedule_editor: button-driven editor for three feed-time slots with auto-repeat and commit pulse.
module schedule_editor #(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  input  logic       btn_select,
  input  logic       btn_back,
  output logic [5:0] state,
  output logic [1:0] cursor,
  output logic [1:0] field,
  output logic [7:0] hour1,
  output logic [7:0] hour2,
  output logic [7:0] hour3,
  output logic [7:0] min1,
  output logic [7:0] min2,
  output logic [7:0] min3,
  output logic       ampm1,
  output logic       ampm2,
  output logic       ampm3,
  output logic       cfg_valid,
  output logic [1:0] cfg_slot,
  output logic [7:0] cfg_hour,
  output logic [7:0] cfg_min,
  output logic       cfg_ampm
);
  typedef enum logic [5:0] {
    S_E1   = 6'b000001,
    S_E2   = 6'b000010,
    S_E3   = 6'b000100,
    S_IDLE = 6'b001000
  } state_e;
  state_e st_q, st_d;
  logic [4:0] btn, btn_q, e;
  logic [1:0] cur_q, cur_d, fld_q, fld_d, idx;
  logic [2:0][7:0] hr_q, hr_d, mn_q, mn_d;
  logic [2:0] am_q, am_d;
  logic [7:0] sh_hr_q, sh_hr_d, sh_mn_q, sh_mn_d;
  logic sh_am_q, sh_am_d;
  logic cv_q, cv_d, ca_q, ca_d;
  logic [1:0] cs_q, cs_d;
  logic [7:0] ch_q, ch_d, cm_q, cm_d;
  logic [31:0] cnt_q, cnt_d, thr;
  logic rep_q, rep_d;
  logic edit, other_e, up_e, dn_e, held, step, inc, dec;
  assign btn = {btn_back, btn_select, btn_next, btn_down, btn_up};
  assign e = btn & ~btn_q;
  assign edit = st_q != S_IDLE;
  assign idx = st_q == S_E2 ? 2'd1 : st_q == S_E3 ? 2'd2 : 2'd0;
  assign other_e = |e[4:2];
  // a simultaneous or overlapping up/down press is treated as no press
  assign up_e = e[0] & ~btn_down;
  assign dn_e = e[1] & ~btn_up;
  // cnt_q == 0 means no live press, so a button held into EDIT never repeats
  assign held = edit & (btn_up ^ btn_down) & ~other_e & ~e[0] & ~e[1] & (cnt_q != 32'd0);
  assign thr = rep_q ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY);
  assign step = held & (cnt_q == thr);
  assign inc = up_e | (step & btn_up);
  assign dec = dn_e | (step & btn_down);
  always_comb begin
    st_d = st_q;
    cur_d = cur_q;
    fld_d = fld_q;
    hr_d = hr_q;
    mn_d = mn_q;
    am_d = am_q;
    sh_hr_d = sh_hr_q;
    sh_mn_d = sh_mn_q;
    sh_am_d = sh_am_q;
    cv_d = 1'b0;
    cs_d = cs_q;
    ch_d = ch_q;
    cm_d = cm_q;
    ca_d = ca_q;
    cnt_d = 32'd0;
    rep_d = 1'b0;
    if (!edit) begin
      if (e[3]) begin
        sh_hr_d = hr_q[cur_q];
        sh_mn_d = mn_q[cur_q];
        sh_am_d = am_q[cur_q];
        fld_d = 2'd0;
        st_d = cur_q == 2'd0 ? S_E1 : cur_q == 2'd1 ? S_E2 : S_E3;
      end else if (up_e) cur_d = cur_q == 2'd0 ? 2'd2 : cur_q - 2'd1;
      else if (dn_e) cur_d = cur_q == 2'd2 ? 2'd0 : cur_q + 2'd1;
    end else if (e[4]) st_d = S_IDLE;
    else if (e[3]) begin
      hr_d[idx] = sh_hr_q;
      mn_d[idx] = sh_mn_q;
      am_d[idx] = sh_am_q;
      cv_d = 1'b1;
      cs_d = idx;
      ch_d = sh_hr_q;
      cm_d = sh_mn_q;
      ca_d = sh_am_q;
      st_d = S_IDLE;
    end else if (e[2]) fld_d = fld_q == 2'd2 ? 2'd0 : fld_q + 2'd1;
    else if (inc | dec) begin
      sh_hr_d = fld_q != 2'd0 ? sh_hr_q :
                inc ? (sh_hr_q == 8'd12 ? 8'd1 : sh_hr_q + 8'd1) :
                      (sh_hr_q == 8'd1 ? 8'd12 : sh_hr_q - 8'd1);
      sh_mn_d = fld_q != 2'd1 ? sh_mn_q :
                inc ? (sh_mn_q == 8'd59 ? 8'd0 : sh_mn_q + 8'd1) :
                      (sh_mn_q == 8'd0 ? 8'd59 : sh_mn_q - 8'd1);
      sh_am_d = fld_q == 2'd2 ? ~sh_am_q : sh_am_q;
    end
    if (edit & ~other_e & (up_e | dn_e)) cnt_d = 32'd1;
    else if (held) begin
      cnt_d = step ? 32'd1 : cnt_q + 32'd1;
      rep_d = rep_q | step;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= S_IDLE;
      btn_q <= '0;
      cur_q <= '0;
      fld_q <= '0;
      hr_q <= {8'd6, 8'd12, 8'd7};
      mn_q <= '0;
      am_q <= 3'b110;
      sh_hr_q <= '0;
      sh_mn_q <= '0;
      sh_am_q <= 1'b0;
      cv_q <= 1'b0;
      cs_q <= '0;
      ch_q <= '0;
      cm_q <= '0;
      ca_q <= 1'b0;
      cnt_q <= '0;
      rep_q <= 1'b0;
    end else begin
      st_q <= st_d;
      btn_q <= btn;
      cur_q <= cur_d;
      fld_q <= fld_d;
      hr_q <= hr_d;
      mn_q <= mn_d;
      am_q <= am_d;
      sh_hr_q <= sh_hr_d;
      sh_mn_q <= sh_mn_d;
      sh_am_q <= sh_am_d;
      cv_q <= cv_d;
      cs_q <= cs_d;
      ch_q <= ch_d;
      cm_q <= cm_d;
      ca_q <= ca_d;
      cnt_q <= cnt_d;
      rep_q <= rep_d;
    end
  end
  assign state = st_q;
  assign cursor = cur_q;
  assign field = fld_q;
  assign hour1 = st_q == S_E1 ? sh_hr_q : hr_q[0];
  assign hour2 = st_q == S_E2 ? sh_hr_q : hr_q[1];
  assign hour3 = st_q == S_E3 ? sh_hr_q : hr_q[2];
  assign min1 = st_q == S_E1 ? sh_mn_q : mn_q[0];
  assign min2 = st_q == S_E2 ? sh_mn_q : mn_q[1];
  assign min3 = st_q == S_E3 ? sh_mn_q : mn_q[2];
  assign ampm1 = st_q == S_E1 ? sh_am_q : am_q[0];
  assign ampm2 = st_q == S_E2 ? sh_am_q : am_q[1];
  assign ampm3 = st_q == S_E3 ? sh_am_q : am_q[2];
  assign cfg_valid = cv_q;
  assign cfg_slot = cs_q;
  assign cfg_hour = ch_q;
  assign cfg_min = cm_q;
  assign cfg_ampm = ca_q;
endmodule

// File: tb/tb_schedule_editor.sv
// tb_schedule_editor: directed plus randomized checks of schedule_editor against a slot-level reference model.
module tb_schedule_editor;
  localparam int D = 10;
  localparam int P = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_next = 1'b0, btn_select = 1'b0, btn_back = 1'b0;
  logic [5:0] state;
  logic [1:0] cursor, field, cfg_slot;
  logic [7:0] hour1, hour2, hour3, min1, min2, min3, cfg_hour, cfg_min;
  logic ampm1, ampm2, ampm3, cfg_valid, cfg_ampm;
  int total = 0, fails = 0;
  int m_hr[3], m_mn[3], m_am[3];
  int m_mode, m_cur, m_fld, s_hr, s_mn, s_am;
  int c_slot, c_hr, c_mn, c_am;

  schedule_editor #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_next(btn_next),
    .btn_select(btn_select), .btn_back(btn_back), .state(state), .cursor(cursor), .field(field),
    .hour1(hour1), .hour2(hour2), .hour3(hour3), .min1(min1), .min2(min2), .min3(min3),
    .ampm1(ampm1), .ampm2(ampm2), .ampm3(ampm3), .cfg_valid(cfg_valid), .cfg_slot(cfg_slot),
    .cfg_hour(cfg_hour), .cfg_min(cfg_min), .cfg_ampm(cfg_ampm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_hr = '{7, 12, 6};
    m_mn = '{0, 0, 0};
    m_am = '{0, 1, 1};
    m_mode = 0; m_cur = 0; m_fld = 0;
    s_hr = 0; s_mn = 0; s_am = 0;
    c_slot = 0; c_hr = 0; c_mn = 0; c_am = 0;
  endtask

  // d = +1 for up, -1 for down, applied to the field being edited
  task automatic m_adj(input int d);
    if (m_fld == 0) s_hr = ((s_hr - 1 + d + 12) % 12) + 1;
    else if (m_fld == 1) s_mn = (s_mn + d + 60) % 60;
    else s_am = 1 - s_am;
  endtask

  // b: 0 up, 1 down, 2 next, 3 select, 4 back
  task automatic m_apply(input int b);
    if (m_mode == 0) begin
      if (b == 0) m_cur = (m_cur + 2) % 3;
      else if (b == 1) m_cur = (m_cur + 1) % 3;
      else if (b == 3) begin
        s_hr = m_hr[m_cur]; s_mn = m_mn[m_cur]; s_am = m_am[m_cur];
        m_fld = 0; m_mode = m_cur + 1;
      end
    end else begin
      if (b == 4) m_mode = 0;
      else if (b == 3) begin
        m_hr[m_mode-1] = s_hr; m_mn[m_mode-1] = s_mn; m_am[m_mode-1] = s_am;
        c_slot = m_mode - 1; c_hr = s_hr; c_mn = s_mn; c_am = s_am;
        m_mode = 0;
      end else if (b == 2) m_fld = (m_fld + 1) % 3;
      else m_adj(b == 0 ? 1 : -1);
    end
  endtask

  function automatic int dh(input int k);
    return m_mode == k + 1 ? s_hr : m_hr[k];
  endfunction
  function automatic int dm(input int k);
    return m_mode == k + 1 ? s_mn : m_mn[k];
  endfunction
  function automatic int da(input int k);
    return m_mode == k + 1 ? s_am : m_am[k];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), m_mode == 0 ? 32'd8 : 32'(1 << (m_mode - 1)));
    chk({tag, ".cursor"}, 32'(cursor), 32'(m_cur));
    chk({tag, ".field"}, 32'(field), 32'(m_fld));
    chk({tag, ".hour1"}, 32'(hour1), 32'(dh(0)));
    chk({tag, ".hour2"}, 32'(hour2), 32'(dh(1)));
    chk({tag, ".hour3"}, 32'(hour3), 32'(dh(2)));
    chk({tag, ".min1"}, 32'(min1), 32'(dm(0)));
    chk({tag, ".min2"}, 32'(min2), 32'(dm(1)));
    chk({tag, ".min3"}, 32'(min3), 32'(dm(2)));
    chk({tag, ".ampm"}, {29'd0, ampm3, ampm2, ampm1}, 32'((da(2) << 2) | (da(1) << 1) | da(0)));
    chk({tag, ".cfg"}, {13'd0, cfg_valid, cfg_slot, cfg_hour, cfg_min}, 32'((c_slot << 16) | (c_hr << 8) | c_mn));
    chk({tag, ".cfg_ampm"}, 32'(cfg_ampm), 32'(c_am));
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 0) btn_up = v;
    else if (b == 1) btn_down = v;
    else if (b == 2) btn_next = v;
    else if (b == 3) btn_select = v;
    else btn_back = v;
  endtask

  task automatic press(input int b);
    logic exp_commit;
    exp_commit = (m_mode != 0) && (b == 3);
    set_btn(b, 1'b1);
    cyc();
    chk("press.cfg_valid", 32'(cfg_valid), 32'(exp_commit));
    m_apply(b);
    set_btn(b, 1'b0);
    cyc();
    check_all("press");
  endtask

  // steps land at hold offsets 0, D, D+P, D+2P, ... while in EDIT
  task automatic hold(input int b, input int len);
    int n;
    set_btn(b, 1'b1);
    repeat (len) cyc();
    set_btn(b, 1'b0);
    cyc();
    n = (m_mode == 0) ? 1 : 1 + ((len - 1 >= D) ? (len - 1 - D) / P + 1 : 0);
    repeat (n) m_apply(b);
    check_all("hold");
  endtask

  task automatic both();
    btn_up = 1'b1; btn_down = 1'b1;
    repeat (3) cyc();
    btn_up = 1'b0; btn_down = 1'b0;
    cyc();
    check_all("both");
  endtask

  initial begin
    m_reset();
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    chk("rst.state", 32'(state), 32'd8);
    chk("rst.slot1", {hour1, min1, 7'd0, ampm1}, {8'd7, 8'd0, 8'd0});
    chk("rst.slot2", {hour2, 7'd0, ampm2}, {8'd12, 8'd1});
    chk("rst.slot3", {hour3, 7'd0, ampm3}, {8'd6, 8'd1});
    chk("rst.cfg_valid", 32'(cfg_valid), 32'd0);
    check_all("rst");
    press(0);
    chk("idle_up_wrap", 32'(cursor), 32'd2);
    press(3);
    chk("sel_state", 32'(state), 32'd4);
    chk("sel_field", 32'(field), 32'd0);
    press(4);
    press(1);
    press(3);
    repeat (6) press(0);
    chk("hour_wrap", 32'(hour1), 32'd1);
    chk("hour_ampm", 32'(ampm1), 32'd0);
    press(2);
    press(1);
    chk("min_wrap", 32'(min1), 32'd59);
    press(4);
    press(1);
    press(3);
    press(2);
    press(2);
    press(0);
    chk("ampm_toggle", 32'(ampm2), 32'd0);
    btn_select = 1'b1;
    cyc();
    chk("commit.pulse", {cfg_valid, cfg_slot, cfg_hour, cfg_min, 7'd0, cfg_ampm}, {1'b1, 2'd1, 8'd12, 8'd0, 8'd0});
    chk("commit.idle", 32'(state), 32'd8);
    m_apply(3);
    btn_select = 1'b0;
    cyc();
    check_all("commit");
    press(1);
    press(3);
    press(0);
    press(4);
    chk("back_discard", 32'(hour3), 32'd6);
    press(3);
    both();
    hold(0, 20);
    press(2);
    hold(0, 20);
    chk("repeat_min", 32'(min3), 32'd4);
    btn_up = 1'b1;
    repeat (7) cyc();
    reset = 1'b0;
    #1;
    chk("rst_mid.state", 32'(state), 32'd8);
    chk("rst_mid.hour3", {hour3, min3, cfg_valid}, {8'd6, 8'd0, 1'b0});
    btn_up = 1'b0;
    cyc();
    reset = 1'b1;
    m_reset();
    cyc();
    check_all("rst_mid");
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) press($urandom_range(0, 4));
      else if (r <= 7) hold($urandom_range(0, 1), $urandom_range(1, 30));
      else both();
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/schedule_editor.md
# schedule_editor

Button-driven editor for the three feed-time slots shown on the edit screen. It turns debounced front-panel buttons into slot selection, field selection, and hour/minute/AM-PM edits, with auto-repeat on held up/down buttons. It drives the edit-screen renderer's `state`, `hour*`, `min*` and `ampm*` inputs. On commit, it emits a one-cycle configuration write toward the feeder scheduler.

## Interface
Parameters:
- `REPEAT_DELAY`, default 25_000_000: cycles up/down must be held before the first auto-repeat step.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent auto-repeat steps.

Ports:
- `clk`  in  1  system clock; everything on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserts immediately, releases synchronously to `clk`).
- `btn_up`, `btn_down`, `btn_next`, `btn_select`, `btn_back`  in  1 each  debounced, synchronous level buttons; high = pressed.
- `state`  out  6  one-hot mode: 6'b000001/000010/000100 = editing slot 1/2/3; 6'b001000 = idle; bits 5:4 always 0.
- `cursor`  out  2  slot highlighted in idle (0..2).
- `field`  out  2  field being edited: 0 hour, 1 minute, 2 AM/PM; value 3 is never driven.
- `hour1`, `hour2`, `hour3`  out  8 each  displayed hour, binary 1..12.
- `min1`, `min2`, `min3`  out  8 each  displayed minute, binary 0..59.
- `ampm1`, `ampm2`, `ampm3`  out  1 each  0 = AM, 1 = PM.
- `cfg_valid`  out  1  one-cycle pulse on commit.
- `cfg_slot`  out  2  committed slot index, 0..2.
- `cfg_hour`, `cfg_min`  out  8 each  committed hour and minute values.
- `cfg_ampm`  out  1  committed AM/PM value.

## Operation
- **Storage.** Three committed slot registers (hour, min, ampm) plus one shadow register set.
- **Reset values:**
  - Slot 1 = 7:00 AM; slot 2 = 12:00 PM; slot 3 = 6:00 PM.
  - `state` = IDLE, `cursor` = 0, `field` = 0.
  - `cfg_valid` = 0, all `cfg_*` = 0, shadow = 0, repeat counter = 0.
- **Displayed outputs.** Slot k's `hour`/`min`/`ampm` show the shadow while `state` is EDIT_k; otherwise they show the committed value.
- **Button edges.** Each button is registered. A press event is a rising edge: current high, previous low.
- **One action per cycle.** Priority is back > select > next > up/down. Up and down pressed together produce no up/down action.
- **IDLE:**
  - up: `cursor` decrements, 0 wraps to 2.
  - down: `cursor` increments, 2 wraps to 0.
  - select: shadow ← committed[`cursor`], `field` ← 0, `state` ← EDIT_(`cursor`+1).
  - next and back: ignored.
- **EDIT_k:**
  - next: `field` cycles 0→1→2→0.
  - up/down on hour: +1/−1; 12 wraps to 1 and 1 wraps to 12. AM/PM does not change.
  - up/down on minute: +1/−1; 59 wraps to 0 and 0 wraps to 59. Hour does not change.
  - up or down on AM/PM: toggles.
  - select: committed[k−1] ← shadow; `cfg_valid` = 1 for one cycle with `cfg_slot` = k−1 and `cfg_*` = shadow; `state` ← IDLE; `cursor` unchanged.
  - back: shadow discarded, `state` ← IDLE, no `cfg_valid`.
- **Auto-repeat (EDIT only):**
  - While exactly one of up/down stays high after its edge, a counter runs.
  - At REPEAT_DELAY cycles after the edge, one extra step occurs, then another every REPEAT_PERIOD cycles.
  - The counter clears on release, when both buttons are high, on any other button edge, and on leaving EDIT.
  - Repeat steps also apply to the AM/PM field.
- **Outputs held.** `cfg_*` keep their last committed values between pulses.

## Timing
- **Action latency.** A button high at edge N with low at edge N−1 → outputs reflect the action after edge N. No combinational path from buttons to outputs.
- **Commit timing.** `cfg_valid` is high in exactly the one cycle following the commit edge. In that same cycle `state` = IDLE and the display shows the new committed values.
- **Reset mid-edit.** Asserting `reset` mid-edit drops to the reset values immediately. The shadow is lost and `cfg_valid` stays low.
- **Held button across mode change.** A button held across a mode change produces no new event until it is released and pressed again. The repeat counter is restarted.
- **Repeat timing.** With up held continuously from edge N, steps occur at edges N, N+REPEAT_DELAY, N+REPEAT_DELAY+REPEAT_PERIOD, and so on.

## Test plan
- Reset then release: `state` = 6'b001000; `hour1`/`min1`/`ampm1` = 7/0/0; `hour2` = 12 with `ampm2` = 1; `hour3` = 6 with `ampm3` = 1; `cfg_valid` = 0.
- IDLE, up pressed at `cursor` = 0 → `cursor` = 2. Select → `state` = 6'b000100, `field` = 0.
- EDIT_1 on hour, up pressed 6 times from 7 → `hour1` = 1 and `ampm1` unchanged. Next, then down pressed once from 0 → `min1` = 59.
- EDIT_2: toggle AM/PM to 0, then select → one-cycle `cfg_valid` with `cfg_slot` = 1, `cfg_hour` = 12, `cfg_min` = 0, `cfg_ampm` = 0. `state` returns to IDLE.
- EDIT_3: change the hour, then back → `hour3` reads 6 again and no `cfg_valid` appears. Up and down pressed together → no change.
- REPEAT_DELAY = 10, REPEAT_PERIOD = 4; hold up on minute for 20 cycles from 0 → steps at cycles 0, 10, 14, 18, so `min` = 4. Release, assert `reset` mid-hold → reset values at once.
